// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: EXU/LSU request channels, register-file write port
// and the decode hazard query.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              exu_valid;
    logic              exu_ready;
    logic [ADDR_W-1:0] exu_waddr;
    logic [DATA_W-1:0] exu_wdata;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_waddr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              hazard1;
    logic              hazard2;

    modport master (
        output exu_valid, exu_waddr, exu_wdata,
        input  exu_ready,
        output lsu_valid, lsu_waddr, lsu_wdata,
        input  lsu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        output raddr1, raddr2,
        input  hazard1, hazard2
    );

    modport slave (
        input  exu_valid, exu_waddr, exu_wdata,
        output exu_ready,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        output lsu_ready,
        output rf_we, rf_waddr, rf_wdata,
        input  raddr1, raddr2,
        output hazard1, hazard2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: one-entry EXU/LSU buffers feeding the register-file write port.
// Define WB_ARB_HAZARD_EN to build the pending-write hazard comparators.
module regfile_wb_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic              exu_vld_p0, lsu_vld_p0;
    logic [ADDR_W-1:0] exu_addr_p0, lsu_addr_p0;
    logic [DATA_W-1:0] exu_data_p0, lsu_data_p0;
    logic              lsu_first;
    logic [2:0]        starve_cnt;
    logic              rf_we_p1;
    logic [ADDR_W-1:0] rf_waddr_p1;
    logic [DATA_W-1:0] rf_wdata_p1;

    logic exu_live, lsu_live, same_addr;
    logic gnt_exu, gnt_lsu;
    logic exu_drain, lsu_drain;
    logic exu_load, lsu_load;

    always_comb begin
        exu_live  = exu_vld_p0 & (exu_addr_p0 != '0);
        lsu_live  = lsu_vld_p0 & (lsu_addr_p0 != '0);
        same_addr = exu_live & lsu_live & (exu_addr_p0 == lsu_addr_p0);
        gnt_exu   = 1'b0;
        gnt_lsu   = 1'b0;
        if (same_addr) begin
            gnt_lsu = lsu_first;
            gnt_exu = ~lsu_first;
        end else if (exu_live && starve_cnt == STARVE_LIM) begin
            gnt_exu = 1'b1;
        end else if (lsu_live) begin
            gnt_lsu = 1'b1;
        end else if (exu_live) begin
            gnt_exu = 1'b1;
        end
    end

    // An x0 entry drains like a grant, so the source can refill behind it.
    assign exu_drain = gnt_exu | (exu_vld_p0 & (exu_addr_p0 == '0));
    assign lsu_drain = gnt_lsu | (lsu_vld_p0 & (lsu_addr_p0 == '0));

    assign bus.exu_ready = rst_n & (~exu_vld_p0 | exu_drain);
    assign bus.lsu_ready = rst_n & (~lsu_vld_p0 | lsu_drain);
    assign exu_load      = bus.exu_valid & bus.exu_ready;
    assign lsu_load      = bus.lsu_valid & bus.lsu_ready;

    // p0: request buffers, age flag and starvation counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exu_vld_p0 <= 1'b0;
            lsu_vld_p0 <= 1'b0;
            lsu_first  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (exu_load)       exu_vld_p0 <= 1'b1;
            else if (exu_drain) exu_vld_p0 <= 1'b0;
            if (lsu_load)       lsu_vld_p0 <= 1'b1;
            else if (lsu_drain) lsu_vld_p0 <= 1'b0;

            if (lsu_load && (!exu_vld_p0 || exu_load))
                lsu_first <= 1'b1;
            else if (exu_load && !lsu_vld_p0)
                lsu_first <= 1'b0;

            if (!exu_vld_p0 || gnt_exu)
                starve_cnt <= '0;
            else if (exu_addr_p0 != '0 && starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (exu_load) begin
            exu_addr_p0 <= bus.exu_waddr;
            exu_data_p0 <= bus.exu_wdata;
        end
        if (lsu_load) begin
            lsu_addr_p0 <= bus.lsu_waddr;
            lsu_data_p0 <= bus.lsu_wdata;
        end
    end

    // p1: registered register-file write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_p1    <= 1'b0;
            rf_waddr_p1 <= '0;
            rf_wdata_p1 <= '0;
        end else begin
            rf_we_p1 <= gnt_exu | gnt_lsu;
            if (gnt_exu) begin
                rf_waddr_p1 <= exu_addr_p0;
                rf_wdata_p1 <= exu_data_p0;
            end else if (gnt_lsu) begin
                rf_waddr_p1 <= lsu_addr_p0;
                rf_wdata_p1 <= lsu_data_p0;
            end
        end
    end

    assign bus.rf_we    = rf_we_p1;
    assign bus.rf_waddr = rf_waddr_p1;
    assign bus.rf_wdata = rf_wdata_p1;

`ifdef WB_ARB_HAZARD_EN
    function automatic logic pending_hit(
        input logic [ADDR_W-1:0] ra,
        input logic              ev, input logic [ADDR_W-1:0] ea,
        input logic              lv, input logic [ADDR_W-1:0] la,
        input logic              wv, input logic [ADDR_W-1:0] wa
    );
        return (ra != '0) & ((ev & (ea == ra)) | (lv & (la == ra)) | (wv & (wa == ra)));
    endfunction

    always_comb begin
        bus.hazard1 = pending_hit(bus.raddr1, exu_vld_p0, exu_addr_p0,
                                  lsu_vld_p0, lsu_addr_p0, rf_we_p1, rf_waddr_p1);
        bus.hazard2 = pending_hit(bus.raddr2, exu_vld_p0, exu_addr_p0,
                                  lsu_vld_p0, lsu_addr_p0, rf_we_p1, rf_waddr_p1);
    end
`else
    assign bus.hazard1 = 1'b0;
    assign bus.hazard2 = 1'b0;
`endif
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. It accepts write requests from the execute unit (EXU) and the load/store unit (LSU) over valid/ready handshakes, holds each in a one-entry buffer, and grants one per cycle. The grant drives a registered `we/waddr/wdata` triple straight into the register file. It also reports pending-write hazards for the two read addresses, so decode can stall.

## Interface
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, register data width
- `STARVE_MAX`, 3, consecutive lost EXU arbitration cycles before EXU is forced to win (1..7)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset; synchronous and active-low
- `exu_valid`  in  1  EXU write request
- `exu_ready`  out  1  EXU request accepted this cycle when high with `exu_valid`
- `exu_waddr`  in  ADDR_W  EXU destination register
- `exu_wdata`  in  DATA_W  EXU write data
- `lsu_valid` / `lsu_ready` / `lsu_waddr` / `lsu_wdata`: same as the EXU ports, for the LSU
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  ADDR_W  register-file write address (registered)
- `rf_wdata`  out  DATA_W  register-file write data (registered)
- `raddr1`, `raddr2`  in  ADDR_W  decode read addresses
- `hazard1`, `hazard2`  out  1  pending write to `raddr1` / `raddr2`

## Operation
**Buffers**
- One buffer per source, each holding valid, addr and data.
- `src_ready = rst_n & (~buf_valid | src_granted)`, so a new request can be accepted in the same cycle the buffer drains.
- A handshake loads the buffer at the next edge.

**x0 writes**
- A buffer with addr 0 is cleared the cycle after loading.
- It never competes for the grant, never asserts `rf_we`, and does not affect the starvation counter.

**Age flag**
- `lsu_first` is set when the LSU buffer loads while the EXU buffer is empty or also loading.
- It is cleared when the EXU buffer loads while the LSU buffer is empty.
- It only matters when both buffers are valid.

**Grant priority (highest first)**
1. Both buffers valid with the same addr: the older entry (per `lsu_first`) wins.
2. `starve_cnt == STARVE_MAX`: EXU wins.
3. Otherwise LSU wins.
- Only one grant is made per cycle.

**Starvation counter**
- `starve_cnt` (3 bits) increments when the EXU buffer is valid, non-zero addr, and not granted.
- It clears on an EXU grant or when the EXU buffer is empty.
- It saturates at `STARVE_MAX`.

**Output register**
- On a grant, the next edge sets `rf_we=1`, `rf_waddr/rf_wdata` to the granted entry, and clears that buffer.
- With no grant, `rf_we=0`; `rf_waddr/rf_wdata` hold their previous values.

**Hazard outputs (combinational)**
- `hazardN = (raddrN != 0) & (match in a valid EXU buffer | match in a valid LSU buffer | (rf_we & rf_waddr == raddrN))`.

## Timing
- Reset (`rst_n` low at an edge):
  - buffers invalid, `lsu_first=0`, `starve_cnt=0`
  - `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`
  - `exu_ready = lsu_ready = 0` while `rst_n` is low
  - `hazard1 = hazard2 = 0`
- Reset mid-operation discards all buffered requests with no register-file write.
- Latency: handshake in cycle c → buffer valid in c+1 → `rf_we=1` in c+2 if granted in c+1 → register file updated at the end of c+2.
- Throughput: 1 write per cycle sustained. With both sources streaming, the loser's ready stays low until its buffer drains.
- Simultaneous handshakes from both sources in one cycle are both accepted if both buffers are empty or draining.

## Configuration
- `WB_ARB_HAZARD_EN` defined: the hazard comparators are built as described.
- Undefined: `hazard1` and `hazard2` are tied to 0; `raddr1/raddr2` are unused and no comparator logic is generated.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles with `exu_valid=1` → both readys 0, `rf_we=0`; after release the first EXU request (addr 5, data 0x11) gives `rf_we=1`, `rf_waddr=5`, `rf_wdata=0x11` two cycles after its handshake.
- x0 drop: EXU request with addr 0, data 0xFFFF → `rf_we` never asserts; `exu_ready` is 1 again the following cycle.
- Priority and starvation (`STARVE_MAX=3`): both sources stream distinct addrs every cycle → grant order LSU, LSU, LSU, EXU, repeating; `rf_we` high every cycle.
- Ordering: LSU writes x7=0xA at cycle c, EXU writes x7=0xB at c+1, and both are pending → LSU write reaches `rf_w*` first, then EXU; x7 ends as 0xB.
- Hazard (macro defined): EXU request to x9 is buffered, `raddr1=9` → `hazard1=1` from c+1 through the cycle `rf_we` is asserted for x9; 0 afterwards; `raddr2=0` → `hazard2=0`.
- Hazard (macro undefined): same stimulus → `hazard1` stays 0.
